// File: rtl/dram_stream_buffer.sv
// Store-then-replay buffer: 128-bit input beats are written to DRAM as 64-bit
// Avalon-MM words, read back in order in 2-word bursts, and replayed on a valid/ready stream.
module dram_stream_buffer #(
  parameter int          DDR_DATA_WIDTH = 64,
  parameter int          DDR_ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int          IN_FIFO_DEPTH  = 32,
  parameter int          OUT_FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              data_in,
  input  logic                      valid_in,
  input  logic [19:0]               numData,
  output logic [127:0]              data_out,
  output logic                      valid_out,
  input  logic                      ready,
  input  logic                      local_init_done,
  input  logic                      amm_wait,
  output logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  input  logic                      amm_rvalid,
  input  logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  output logic                      amm_ren,
  output logic                      amm_wen,
  output logic [5:0]                amm_burstcount
);
  localparam int IAW = $clog2(IN_FIFO_DEPTH);
  localparam int OAW = $clog2(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2, S_DONE = 2'd3} state_t;
  state_t r_state;

  logic [127:0]        r_in_mem [IN_FIFO_DEPTH];
  logic [IAW-1:0]      r_in_wr, r_in_rd;
  logic [IAW:0]        r_in_cnt;
  logic [127:0]        r_out_mem [OUT_FIFO_DEPTH];
  logic [OAW-1:0]      r_out_wr, r_out_rd;
  logic [OAW:0]        r_out_cnt, r_outst;
  logic [19:0]         r_in_acc, r_num, r_wbeats, r_rbursts, r_handed;
  logic [63:0]         r_whi, r_rlo;
  logic                r_lo, r_rhalf;

  logic                w_in_push, w_in_pop, w_acc, w_cmd_free, w_hi_next;
  logic                w_rd_issue, w_rword, w_out_push, w_out_pop;
  logic [19:0]         w_limit;
  logic [OAW+1:0]      w_free, w_committed;

  function automatic logic [DDR_ADDR_WIDTH-1:0] beat_addr(input logic [19:0] idx);
    beat_addr = DDR_ADDR_WIDTH'(BASE_ADDR) + DDR_ADDR_WIDTH'({idx, 1'b0});
  endfunction

  always_comb begin
    // Before numData is latched the live input bounds how many beats are kept.
    w_limit     = (r_state == S_IDLE) ? numData : r_num;
    w_in_push   = valid_in && (r_state != S_DONE) && (r_in_acc < w_limit) &&
                  (r_in_cnt != (IAW+1)'(IN_FIFO_DEPTH));
    w_acc       = (amm_ren | amm_wen) & ~amm_wait;
    w_cmd_free  = ~(amm_ren | amm_wen) | w_acc;
    w_hi_next   = amm_wen & r_lo;
    w_in_pop    = (r_state == S_WRITE) && w_cmd_free && !w_hi_next &&
                  (r_wbeats < r_num) && (r_in_cnt != '0);
    w_free      = (OAW+2)'(OUT_FIFO_DEPTH) - (OAW+2)'(r_out_cnt);
    w_committed = (OAW+2)'(r_outst) + (OAW+2)'(r_out_cnt);
    w_rd_issue  = (r_state == S_READ) && w_cmd_free && (r_rbursts < r_num) && (w_free > w_committed);
    w_rword     = amm_rvalid && (r_state == S_READ) && (r_outst != '0);
    w_out_push  = w_rword && r_rhalf;
    w_out_pop   = valid_out && ready;
  end

  assign data_out  = r_out_mem[r_out_rd];
  assign valid_out = (r_out_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_in_push) r_in_mem[r_in_wr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
      r_in_acc <= '0;
    end else begin
      if (w_in_push) begin
        r_in_wr  <= r_in_wr + 1'b1;
        r_in_acc <= r_in_acc + 20'd1;
      end
      if (w_in_pop) r_in_rd <= r_in_rd + 1'b1;
      r_in_cnt <= r_in_cnt + (IAW+1)'(w_in_push) - (IAW+1)'(w_in_pop);
    end
  end

  // Return words pair up low-then-high into one beat; storage is cleared so data_out reads 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) r_out_mem[i] <= '0;
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
      r_rlo     <= '0;
      r_rhalf   <= 1'b0;
    end else begin
      if (w_rword) begin
        r_rhalf <= ~r_rhalf;
        if (!r_rhalf) r_rlo <= amm_rdata;
      end
      if (w_out_push) begin
        r_out_mem[r_out_wr] <= {amm_rdata, r_rlo};
        r_out_wr            <= r_out_wr + 1'b1;
      end
      if (w_out_pop) r_out_rd <= r_out_rd + 1'b1;
      r_out_cnt <= r_out_cnt + (OAW+1)'(w_out_push) - (OAW+1)'(w_out_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_num          <= '0;
      r_wbeats       <= '0;
      r_rbursts      <= '0;
      r_handed       <= '0;
      r_outst        <= '0;
      r_whi          <= '0;
      r_lo           <= 1'b0;
      amm_addr       <= '0;
      amm_wdata      <= '0;
      amm_ren        <= 1'b0;
      amm_wen        <= 1'b0;
      amm_burstcount <= '0;
    end else begin
      if (w_out_pop) r_handed <= r_handed + 20'd1;
      r_outst <= r_outst + (OAW+1)'(w_rd_issue) - (OAW+1)'(w_out_push);
      case (r_state)
        S_IDLE: begin
          if (local_init_done) begin
            r_num   <= numData;
            r_state <= (numData == 20'd0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_cmd_free) begin
            if (w_hi_next) begin
              amm_addr  <= amm_addr + DDR_ADDR_WIDTH'(1);
              amm_wdata <= r_whi;
              r_lo      <= 1'b0;
            end else if (w_in_pop) begin
              r_whi          <= r_in_mem[r_in_rd][127:64];
              amm_wdata      <= r_in_mem[r_in_rd][63:0];
              amm_addr       <= beat_addr(r_wbeats);
              amm_wen        <= 1'b1;
              amm_burstcount <= 6'd1;
              r_lo           <= 1'b1;
              r_wbeats       <= r_wbeats + 20'd1;
            end else begin
              amm_wen <= 1'b0;
              if (r_wbeats == r_num) r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_cmd_free) begin
            amm_ren <= w_rd_issue;
            if (w_rd_issue) begin
              amm_addr       <= beat_addr(r_rbursts);
              amm_burstcount <= 6'd2;
              r_rbursts      <= r_rbursts + 20'd1;
            end
          end
          if (r_handed == r_num) r_state <= S_DONE;
        end
        S_DONE: begin
          amm_ren <= 1'b0;
          amm_wen <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_stream_buffer.sv
// Self-checking bench for dram_stream_buffer: an AMM memory model plus scoreboards
// for expected write commands and expected output beats.
module tb_dram_stream_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic [19:0]  numData = '0;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready = 1'b0;
  logic         local_init_done = 1'b0;
  logic         amm_wait = 1'b0;
  logic [31:0]  amm_addr;
  logic         amm_rvalid = 1'b0;
  logic [63:0]  amm_rdata = '0;
  logic [63:0]  amm_wdata;
  logic         amm_ren, amm_wen;
  logic [5:0]   amm_burstcount;

  always #5 clk = ~clk;

  dram_stream_buffer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .numData(numData),
    .data_out(data_out), .valid_out(valid_out), .ready(ready),
    .local_init_done(local_init_done), .amm_wait(amm_wait), .amm_addr(amm_addr),
    .amm_rvalid(amm_rvalid), .amm_rdata(amm_rdata), .amm_wdata(amm_wdata),
    .amm_ren(amm_ren), .amm_wen(amm_wen), .amm_burstcount(amm_burstcount)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0]  ddr [logic [31:0]];
  logic [63:0]  rq[$];
  logic [127:0] exp_out[$];
  logic [95:0]  exp_wr[$];
  int in_left, n_sent, n_vout, n_cmd, rd_idx;
  int in_pct, wait_pct, rdy_pct, gap_pct;
  bit pat, spur;
  bit prev_stall, prev_vstall;
  logic [103:0] p_cmd;
  logic [127:0] p_dout;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    ddr.delete(); rq.delete(); exp_out.delete(); exp_wr.delete();
    n_sent = 0; n_vout = 0; n_cmd = 0; rd_idx = 0;
    prev_stall = 1'b0; prev_vstall = 1'b0; spur = 1'b0;
    valid_in = 1'b0; amm_rvalid = 1'b0; amm_wait = 1'b0; ready = 1'b0;
  endtask

  task automatic set_params(input int n, input int nsend, input int ip, input int wp,
                            input int rp, input int gp, input bit pt);
    numData = 20'(n); in_left = nsend; in_pct = ip; wait_pct = wp;
    rdy_pct = rp; gap_pct = gp; pat = pt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dout"}, data_out, '0);
    check_val({tag, "_ctrl"}, {valid_out, amm_ren, amm_wen, amm_burstcount, amm_addr, amm_wdata}, '0);
  endtask

  task automatic do_reset();
    local_init_done = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b1;
  endtask

  // One clock of bench activity, sampled 1 time unit after the rising edge.
  task automatic step();
    logic acc;
    logic [95:0] ew;
    logic [127:0] beat;
    @(posedge clk); #1;
    if (prev_stall) check_val("wait_hold", {amm_ren, amm_wen, amm_burstcount, amm_addr, amm_wdata}, p_cmd);
    if (amm_ren || amm_wen) check_val("ren_wen_excl", amm_ren & amm_wen, 0);
    if (prev_vstall) begin
      check_val("vout_hold", valid_out, 1);
      check_val("dout_hold", data_out, p_dout);
    end
    if (rq.size() != 0 && $urandom_range(99) >= gap_pct) begin
      amm_rvalid = 1'b1; amm_rdata = rq.pop_front();
    end else if (spur && $urandom_range(3) == 0) begin
      amm_rvalid = 1'b1; amm_rdata = {$urandom, $urandom};
    end else begin
      amm_rvalid = 1'b0; amm_rdata = '0;
    end
    amm_wait   = ($urandom_range(99) < wait_pct);
    acc        = (amm_ren || amm_wen) && !amm_wait;
    prev_stall = (amm_ren || amm_wen) && amm_wait;
    p_cmd      = {amm_ren, amm_wen, amm_burstcount, amm_addr, amm_wdata};
    if (acc) n_cmd++;
    if (acc && amm_wen) begin
      ddr[amm_addr] = amm_wdata;
      check_val("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        check_val("wr_addr", amm_addr, ew[95:64]);
        check_val("wr_data", amm_wdata, ew[63:0]);
      end
      check_val("wr_burst", amm_burstcount, 1);
    end
    if (acc && amm_ren) begin
      check_val("rd_addr", amm_addr, 2 * rd_idx);
      check_val("rd_burst", amm_burstcount, 2);
      rq.push_back(ddr.exists(amm_addr) ? ddr[amm_addr] : 64'hDEAD_0000_0000_DEAD);
      rq.push_back(ddr.exists(amm_addr + 32'd1) ? ddr[amm_addr + 32'd1] : 64'hDEAD_0000_0000_DEAD);
      rd_idx++;
    end
    ready = ($urandom_range(99) < rdy_pct);
    if (valid_out && ready) begin
      n_vout++;
      check_val("out_expected", exp_out.size() != 0, 1);
      if (exp_out.size() != 0) check_val("data_out", data_out, exp_out.pop_front());
    end
    prev_vstall = valid_out && !ready;
    p_dout      = data_out;
    if (in_left > 0 && $urandom_range(99) < in_pct) begin
      beat = pat ? {32'hBEEF_0000 | 32'(n_sent), 32'h5A5A_0000 | 32'(n_sent),
                    32'hC0DE_0000 | 32'(n_sent), 32'(n_sent)}
                 : {$urandom, $urandom, $urandom, $urandom};
      valid_in = 1'b1; data_in = beat;
      if (n_sent < int'(numData)) begin
        exp_out.push_back(beat);
        exp_wr.push_back({32'(2 * n_sent), beat[63:0]});
        exp_wr.push_back({32'(2 * n_sent + 1), beat[127:64]});
      end
      n_sent++; in_left--;
    end else begin
      valid_in = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_until(input string tag, input int budget);
    int cyc = 0;
    while ((n_vout < int'(numData) || in_left > 0) && cyc < budget) begin
      step();
      cyc++;
    end
    check_val({tag, "_beats_out"}, n_vout, numData);
    check_val({tag, "_sb_left"}, exp_out.size() + exp_wr.size(), 0);
    repeat (10) step();
    check_val({tag, "_cmd_count"}, n_cmd, 3 * int'(numData));
    check_val({tag, "_beats_after"}, n_vout, numData);
  endtask

  initial begin
    #2;
    do_reset();

    // Basic: 4 patterned beats plus 2 extra beats that must be ignored.
    set_params(4, 6, 100, 0, 100, 0, 1'b1);
    local_init_done = 1'b1;
    run_until("basic", 500);

    // Init gating with spurious rvalid while idle.
    do_reset();
    set_params(20, 20, 50, 0, 100, 0, 1'b0);
    spur = 1'b1;
    repeat (50) step();
    check_val("init_hold_cmds", n_cmd, 0);
    check_val("init_hold_vout", n_vout, 0);
    spur = 1'b0;
    local_init_done = 1'b1;
    run_until("init", 3000);

    // Waitrequest toggling and gapped read returns.
    do_reset();
    set_params(1024, 1024, 25, 20, 100, 20, 1'b0);
    local_init_done = 1'b1;
    run_until("wait", 20000);

    // Output backpressure.
    do_reset();
    set_params(1024, 1024, 45, 0, 50, 0, 1'b0);
    local_init_done = 1'b1;
    run_until("bp", 20000);

    // Zero length transfer.
    do_reset();
    set_params(0, 3, 100, 0, 100, 0, 1'b1);
    local_init_done = 1'b1;
    repeat (40) step();
    check_val("zero_cmds", n_cmd, 0);
    check_val("zero_vout", n_vout, 0);

    // Asynchronous reset in the middle of the read phase, then a fresh transfer.
    do_reset();
    set_params(8, 8, 100, 0, 100, 0, 1'b1);
    local_init_done = 1'b1;
    for (int i = 0; i < 500 && rd_idx < 2; i++) step();
    check_val("reached_read", rd_idx >= 2, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midread_rst");
    valid_in = 1'b0; amm_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midread_hold");
    clear_model();
    set_params(2, 2, 100, 0, 100, 0, 1'b0);
    rst = 1'b1;
    run_until("after_rst", 500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
